// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arith_pkg
//  Description : Shared arithmetic definitions for the multi-cycle execution
//                units (divider, multiplier, remainder unit).
//  Revision    : 1.0  initial release
// ============================================================================
package arith_pkg;

    // 3-bit state encoding shared by the iterative arithmetic units
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PREP  = 3'd1;
    localparam logic [2:0] ST_CALC  = 3'd2;
    localparam logic [2:0] ST_FIXUP = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        PREP  = ST_PREP,
        CALC  = ST_CALC,
        FIXUP = ST_FIXUP,
        DONE  = ST_DONE
    } div_state_t;

    // Most negative two's-complement value of a given width (width <= 64)
    function automatic logic [63:0] signed_min(input int width);
        signed_min = 64'd1 << (width - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_restore_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_restore_step
//  Description : One combinational restoring-division step: shift in the next
//                dividend bit, trial-subtract the divisor, keep or restore.
//  Revision    : 1.0  initial release
// ============================================================================
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_dvs_n;
    logic [WIDTH:0] w_diff;
    logic           w_cout;
    // The incoming remainder is always below the divisor, so its MSB is zero
    logic           w_unused_msb;

    assign w_unused_msb = rem_i[WIDTH];
    assign w_shift      = {rem_i[WIDTH-1:0], bit_i};
    assign w_dvs_n      = ~{1'b0, dvs_i};

    // Subtract as shift + ~divisor + 1; carry out set means no borrow
    ripple_carry_adder #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .a_i    (w_shift),
        .b_i    (w_dvs_n),
        .cin_i  (1'b1),
        .sum_o  (w_diff),
        .cout_o (w_cout)
    );

    assign qbit_o = w_cout;
    assign rem_o  = w_cout ? w_diff : w_shift;

endmodule
`default_nettype wire

// File: rtl/ripple_carry_adder.sv
`default_nettype none
// ============================================================================
//  Module      : ripple_carry_adder
//  Description : Plain ripple-carry adder with carry in and carry out.
//  Revision    : 1.0  initial release
// ============================================================================
module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = cin_i;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign sum_o[i]       = a_i[i] ^ b_i[i] ^ w_carry[i];
            assign w_carry[i + 1] = (a_i[i] & b_i[i]) | (a_i[i] & w_carry[i]) |
                                    (b_i[i] & w_carry[i]);
        end
    endgenerate

    assign cout_o = w_carry[WIDTH];

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Iterative restoring integer divider, signed or unsigned,
//                one quotient bit per cycle, valid/ready on both sides.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             overflow
);

    import arith_pkg::*;

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL  = WIDTH'(signed_min(WIDTH));
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;           // raw dividend as accepted
    logic [WIDTH-1:0] b_q, b_d;           // raw divisor as accepted
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;       // |dividend|, becomes |quotient| bit by bit
    logic [WIDTH-1:0] dvs_q, dvs_d;       // |divisor|
    logic [WIDTH:0]   rem_q, rem_d;       // partial remainder
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             dzo_q, dzo_d;
    logic             ovo_q, ovo_d;
    logic             out_valid_q, out_valid_d;

    logic             w_sa;
    logic             w_sb;
    logic [WIDTH:0]   w_step_rem;
    logic             w_qbit;

    assign w_sa = sgn_q & a_q[WIDTH-1];
    assign w_sb = sgn_q & b_q[WIDTH-1];

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i  (rem_q),
        .bit_i  (dvd_q[WIDTH-1]),
        .dvs_i  (dvs_q),
        .rem_o  (w_step_rem),
        .qbit_o (w_qbit)
    );

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dz_q        <= 1'b0;
            ov_q        <= 1'b0;
            quo_out_q   <= '0;
            rem_out_q   <= '0;
            dzo_q       <= 1'b0;
            ovo_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            sgn_q       <= sgn_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            dz_q        <= dz_d;
            ov_q        <= ov_d;
            quo_out_q   <= quo_out_d;
            rem_out_q   <= rem_out_d;
            dzo_q       <= dzo_d;
            ovo_q       <= ovo_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state, datapath update and handshake outputs
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sgn_d       = sgn_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        dz_d        = dz_q;
        ov_d        = ov_q;
        quo_out_d   = quo_out_q;
        rem_out_d   = rem_out_q;
        dzo_d       = dzo_q;
        ovo_d       = ovo_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = dividend;
                    b_d     = divisor;
                    sgn_d   = is_signed;
                    state_d = PREP;
                end
            end
            PREP: begin
                dvd_d  = w_sa ? (~a_q + ONE) : a_q;
                dvs_d  = w_sb ? (~b_q + ONE) : b_q;
                qneg_d = w_sa ^ w_sb;
                rneg_d = w_sa;
                rem_d  = '0;
                cnt_d  = CNT_LAST;
                dz_d   = (b_q == '0);
                ov_d   = sgn_q && (a_q == MIN_VAL) && (b_q == ALL_ONES);
                // Both special cases have a fixed answer, so no iteration is needed
                state_d = (dz_d || ov_d) ? FIXUP : CALC;
            end
            CALC: begin
                rem_d = w_step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], w_qbit};
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == '0) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                if (dz_q) begin
                    quo_out_d = ALL_ONES;
                    rem_out_d = a_q;
                end else if (ov_q) begin
                    quo_out_d = MIN_VAL;
                    rem_out_d = '0;
                end else begin
                    quo_out_d = qneg_q ? (~dvd_q + ONE) : dvd_q;
                    rem_out_d = rneg_q ? (~rem_q[WIDTH-1:0] + ONE) : rem_q[WIDTH-1:0];
                end
                dzo_d       = dz_q;
                ovo_d       = ov_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid = out_valid_q;
    assign quotient  = quo_out_q;
    assign remainder = rem_out_q;
    assign div_zero  = dzo_q;
    assign overflow  = ovo_q;

endmodule
`default_nettype wire
